bp_cache_assoc: RTL and testbench

- N-way set-associative successor to the direct-mapped branch-predictor cache.
- Stores DWIDTH-bit predictor entries (e.g. 2-bit counters) tagged by full address.
- Provides two combinational read ports for fetch and lookahead, and one synchronous write/allocate port from the resolve stage.
- Uses tree pseudo-LRU replacement per set and adds a single-cycle flush.

---
 rtl/bp_cache_assoc.sv | 136 +++++++++++++
 tb/tb_bp_cache_assoc.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bp_cache_assoc.sv
// Set-associative branch-predictor cache: two zero-latency read ports, one write/allocate port, tree PLRU, flush.
// Writes and flush take effect on the rising edge; there is no backpressure, and every write is accepted.
module bp_cache_assoc #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 2,
  parameter int LINES  = 8,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] ra0,
  output logic [DWIDTH-1:0] dout0,
  output logic              hit0,
  input  logic [AWIDTH-1:0] ra1,
  output logic [DWIDTH-1:0] dout1,
  output logic              hit1,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] din,
  input  logic              we,
  input  logic              flush
);

  localparam int SETS  = LINES / WAYS;
  localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 0;
  localparam int SW    = (SETS > 1) ? IDX_W : 1;
  localparam int TW    = AWIDTH - IDX_W;
  localparam int LW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PW    = (WAYS > 1) ? WAYS - 1 : 1;

  logic              valid_q [SETS][WAYS];
  logic [TW-1:0]     tag_q   [SETS][WAYS];
  logic [DWIDTH-1:0] data_q  [SETS][WAYS];
  logic [PW-1:0]     plru_q  [SETS];

  logic [SW-1:0] idx0, idx1, widx;
  logic [TW-1:0] tag0, tag1, wtag;

  assign tag0 = ra0[AWIDTH-1:IDX_W];
  assign tag1 = ra1[AWIDTH-1:IDX_W];
  assign wtag = wa[AWIDTH-1:IDX_W];

  if (IDX_W > 0) begin : g_idx
    assign idx0 = ra0[IDX_W-1:0];
    assign idx1 = ra1[IDX_W-1:0];
    assign widx = wa[IDX_W-1:0];
  end else begin : g_noidx
    assign idx0 = '0;
    assign idx1 = '0;
    assign widx = '0;
  end

  always_comb begin
    hit0  = 1'b0;
    dout0 = '0;
    hit1  = 1'b0;
    dout1 = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx0][w] && tag_q[idx0][w] == tag0) begin
        hit0  = 1'b1;
        dout0 = data_q[idx0][w];
      end
      if (valid_q[idx1][w] && tag_q[idx1][w] == tag1) begin
        hit1  = 1'b1;
        dout1 = data_q[idx1][w];
      end
    end
  end

  logic          whit, inv_found;
  logic [LW-1:0] hway, inv_way, pway, wway;
  logic [PW-1:0] plru_nxt;
  int            node;

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  always_comb begin
    whit      = 1'b0;
    hway      = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    pway      = '0;
    plru_nxt  = plru_q[widx];
    node      = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[widx][w] && tag_q[widx][w] == wtag) begin
        whit = 1'b1;
        hway = LW'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[widx][w]) begin
        inv_found = 1'b1;
        inv_way   = LW'(w);
      end
    end
    if (WAYS > 1) begin
      for (int l = 0; l < LW; l++) begin
        pway[LW-1-l] = plru_q[widx][node];
        node = 2 * node + 1 + int'(plru_q[widx][node]);
      end
    end
    wway = whit ? hway : (inv_found ? inv_way : pway);
    node = 0;
    if (WAYS > 1) begin
      for (int l = 0; l < LW; l++) begin
        plru_nxt[node] = ~wway[LW-1-l];
        node = 2 * node + 1 + int'(wway[LW-1-l]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else if (we) begin
      valid_q[widx][wway] <= 1'b1;
      plru_q[widx]        <= plru_nxt;
    end
  end

  // Tag/data carry no reset; the valid bits alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    if (reset && !flush && we) begin
      tag_q[widx][wway]  <= wtag;
      data_q[widx][wway] <= din;
    end
  end

endmodule

// File: tb/tb_bp_cache_assoc.sv
// Directed bench for bp_cache_assoc with WAYS=2, LINES=8 (set 0 = 0x0, 0x4, 0x8, 0xC, 0x10).
module tb_bp_cache_assoc;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ra0, ra1, wa;
  logic [1:0]  dout0, dout1, din;
  logic        hit0, hit1, we, flush;
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  bp_cache_assoc #(.AWIDTH(32), .DWIDTH(2), .LINES(8), .WAYS(2)) dut (
    .clk(clk), .reset(reset),
    .ra0(ra0), .dout0(dout0), .hit0(hit0),
    .ra1(ra1), .dout1(dout1), .hit1(hit1),
    .wa(wa), .din(din), .we(we), .flush(flush)
  );

  task automatic wr(input logic [31:0] a, input logic [1:0] d);
    @(negedge clk);
    wa = a; din = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; we = 1'b0; flush = 1'b0;
    ra0 = 32'h0; ra1 = 32'h4; wa = 32'h0; din = 2'b00;
    #1;
    checks++;
    if (hit0 !== 1'b0 || dout0 !== 2'b00 || hit1 !== 1'b0 || dout1 !== 2'b00)
      $display("FAIL reset_state got hit0=%b dout0=%b hit1=%b dout1=%b want 0/00/0/00", hit0, dout0, hit1, dout1);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_miss;
    ra0 = 32'h0;
    #1;
    checks++;
    if (hit0 !== 1'b0 || dout0 !== 2'b00)
      $display("FAIL cold_miss got hit0=%b dout0=%b want 0/00", hit0, dout0);
    else passed++;
  endtask

  task automatic test_allocate;
    @(negedge clk);
    wa = 32'h0; din = 2'b11; we = 1'b1; ra0 = 32'h0; ra1 = 32'h4;
    @(posedge clk);
    #1;
    checks++;
    if (hit0 !== 1'b1 || dout0 !== 2'b11)
      $display("FAIL allocate_p0 got hit0=%b dout0=%b want 1/11", hit0, dout0);
    else passed++;
    checks++;
    if (hit1 !== 1'b0 || dout1 !== 2'b00)
      $display("FAIL allocate_p1 got hit1=%b dout1=%b want 0/00", hit1, dout1);
    else passed++;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_lru_evict;
    logic [31:0] a  [3] = '{32'h4, 32'h8, 32'h0};
    logic        eh [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0]  ed [3] = '{2'b01, 2'b10, 2'b00};
    wr(32'h4, 2'b01);
    wr(32'h8, 2'b10);
    for (int i = 0; i < 3; i++) begin
      ra0 = a[i]; ra1 = a[i];
      #1;
      checks++;
      if (hit0 !== eh[i] || dout0 !== ed[i] || hit1 !== eh[i] || dout1 !== ed[i])
        $display("FAIL lru_evict addr=%h got hit0=%b dout0=%b hit1=%b dout1=%b want %b/%b",
                 a[i], hit0, dout0, hit1, dout1, eh[i], ed[i]);
      else passed++;
    end
  endtask

  task automatic test_write_hit_recency;
    logic [31:0] a  [3] = '{32'h8, 32'h4, 32'hC};
    logic        eh [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  ed [3] = '{2'b00, 2'b00, 2'b11};
    wr(32'h4, 2'b00);
    wr(32'hC, 2'b11);
    for (int i = 0; i < 3; i++) begin
      ra0 = a[i]; ra1 = a[i];
      #1;
      checks++;
      if (hit0 !== eh[i] || dout0 !== ed[i] || hit1 !== eh[i] || dout1 !== ed[i])
        $display("FAIL write_hit_recency addr=%h got hit0=%b dout0=%b hit1=%b dout1=%b want %b/%b",
                 a[i], hit0, dout0, hit1, dout1, eh[i], ed[i]);
      else passed++;
    end
  endtask

  // Set 0 holds {0xC in way0, 0x4 in way1} with PLRU pointing at way1, so 0x10 replaces 0x4.
  task automatic test_read_during_write;
    logic [31:0] a  [3] = '{32'hC, 32'h4, 32'h1};
    logic        eh [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  ed [3] = '{2'b11, 2'b00, 2'b00};
    @(negedge clk);
    ra0 = 32'h10; wa = 32'h10; din = 2'b01; we = 1'b1;
    #1;
    checks++;
    if (hit0 !== 1'b0)
      $display("FAIL rdw_before_edge got hit0=%b want 0", hit0);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (hit0 !== 1'b1 || dout0 !== 2'b01)
      $display("FAIL rdw_after_edge got hit0=%b dout0=%b want 1/01", hit0, dout0);
    else passed++;
    @(negedge clk);
    we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ra1 = a[i];
      #1;
      checks++;
      if (hit1 !== eh[i] || dout1 !== ed[i])
        $display("FAIL rdw_other addr=%h got hit1=%b dout1=%b want %b/%b", a[i], hit1, dout1, eh[i], ed[i]);
      else passed++;
    end
  endtask

  task automatic test_flush;
    logic [31:0] a [3] = '{32'h1, 32'h10, 32'hC};
    @(negedge clk);
    flush = 1'b1; we = 1'b1; wa = 32'h1; din = 2'b11;
    @(negedge clk);
    flush = 1'b0; we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ra0 = a[i]; ra1 = a[i];
      #1;
      checks++;
      if (hit0 !== 1'b0 || hit1 !== 1'b0 || dout0 !== 2'b00 || dout1 !== 2'b00)
        $display("FAIL flush addr=%h got hit0=%b hit1=%b dout0=%b dout1=%b want all 0",
                 a[i], hit0, hit1, dout0, dout1);
      else passed++;
    end
  endtask

  task automatic test_async_reset;
    wr(32'h2, 2'b10);
    wr(32'h7, 2'b01);
    ra0 = 32'h2; ra1 = 32'h7;
    #1;
    checks++;
    if (hit0 !== 1'b1 || dout0 !== 2'b10 || hit1 !== 1'b1 || dout1 !== 2'b01)
      $display("FAIL repopulate got hit0=%b dout0=%b hit1=%b dout1=%b want 1/10/1/01", hit0, dout0, hit1, dout1);
    else passed++;
    @(posedge clk);
    #3;
    reset = 1'b0; we = 1'b1; wa = 32'h3; din = 2'b11;
    #1;
    checks++;
    if (hit0 !== 1'b0 || dout0 !== 2'b00 || hit1 !== 1'b0 || dout1 !== 2'b00)
      $display("FAIL reset_mid_cycle got hit0=%b dout0=%b hit1=%b dout1=%b want 0/00/0/00", hit0, dout0, hit1, dout1);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; we = 1'b0;
    @(negedge clk);
    ra0 = 32'h3; ra1 = 32'h2;
    #1;
    checks++;
    if (hit0 !== 1'b0 || hit1 !== 1'b0)
      $display("FAIL after_release got hit0=%b hit1=%b want 0/0", hit0, hit1);
    else passed++;
    ra0 = 32'h7;
    #1;
    checks++;
    if (hit0 !== 1'b0 || dout0 !== 2'b00)
      $display("FAIL after_release_7 got hit0=%b dout0=%b want 0/00", hit0, dout0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_allocate();
    test_lru_evict();
    test_write_hit_recency();
    test_read_during_write();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
